// File: rtl/counter_pkg.sv
// Shared types and reset constants for the extended up/down counter family.
// Imported by counter_ext and its optional prescaler.
package counter_pkg;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } counter_dir_e;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } counter_mode_e;

    // Per-cycle action after priority resolution: clear > load > step.
    typedef enum logic [1:0] {
        ACT_HOLD  = 2'd0,
        ACT_CLEAR = 2'd1,
        ACT_LOAD  = 2'd2,
        ACT_STEP  = 2'd3
    } counter_act_e;

    localparam int unsigned RST_COUNT    = 0;
    localparam int unsigned RST_PRESCALE = 0;
    localparam logic        RST_TC       = 1'b0;
    localparam logic        RST_OVF      = 1'b0;

    function automatic counter_act_e counter_action(input logic clear,
                                                    input logic load,
                                                    input logic step);
        if (clear) return ACT_CLEAR;
        if (load)  return ACT_LOAD;
        if (step)  return ACT_STEP;
        return ACT_HOLD;
    endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Enable-gated prescaler: o_tick marks every (i_prescale+1)-th enabled cycle.
// Built only when COUNTER_EXT_PRESCALE_EN is defined.
module counter_prescaler
    import counter_pkg::*;
#(
    parameter int unsigned PRESCALE_W = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_en,
    input  logic                  i_restart,
    input  logic [PRESCALE_W-1:0] i_prescale,
    output logic                  o_tick
);

    logic [PRESCALE_W-1:0] pre_q;
    logic [PRESCALE_W-1:0] pre_d;
    logic                  hit;

    assign hit    = (pre_q == i_prescale);
    assign o_tick = hit;

    always_comb begin
        pre_d = pre_q;
        if (i_restart) begin
            pre_d = PRESCALE_W'(RST_PRESCALE);
        end else if (i_en) begin
            pre_d = hit ? PRESCALE_W'(RST_PRESCALE) : pre_q + PRESCALE_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pre_q <= PRESCALE_W'(RST_PRESCALE);
        end else begin
            pre_q <= pre_d;
        end
    end

endmodule

// File: rtl/counter_ext.sv
// Up/down counter with load, programmable terminal value, wrap/saturate mode,
// terminal-count pulse and sticky overflow. Optional prescaler: COUNTER_EXT_PRESCALE_EN.
module counter_ext
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH      = 12,
    parameter int unsigned PRESCALE_W = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_en,
    input  logic                  i_clear,
    input  logic                  i_load,
    input  logic [WIDTH-1:0]      i_load_val,
    input  logic                  i_dir,
    input  logic                  i_mode,
    input  logic [WIDTH-1:0]      i_max,
    input  logic [PRESCALE_W-1:0] i_prescale,
    output logic [WIDTH-1:0]      o_count,
    output logic                  o_tc,
    output logic                  o_ovf
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;

    logic             tick;
    logic             boundary;
    counter_dir_e     dir;
    counter_mode_e    mode;
    counter_act_e     action;

`ifdef COUNTER_EXT_PRESCALE_EN
    // Load and clear both restart the prescale window.
    counter_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_en       (i_en),
        .i_restart  (i_clear | i_load),
        .i_prescale (i_prescale),
        .o_tick     (tick)
    );
`else
    logic unused_prescale;
    assign unused_prescale = ^i_prescale;
    assign tick            = 1'b1;
`endif

    assign dir    = counter_dir_e'(i_dir);
    assign mode   = counter_mode_e'(i_mode);
    assign action = counter_action(i_clear, i_load, i_en & tick);

    // ">=" on the up side lets a loaded value above i_max still hit the boundary.
    assign boundary = (dir == DIR_UP) ? (count_q >= i_max) : (count_q == '0);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        ovf_d   = ovf_q;
        unique case (action)
            ACT_CLEAR: begin
                count_d = WIDTH'(RST_COUNT);
                ovf_d   = 1'b0;
            end
            ACT_LOAD: begin
                count_d = i_load_val;
            end
            ACT_STEP: begin
                if (boundary) begin
                    tc_d  = 1'b1;
                    ovf_d = 1'b1;
                    if (dir == DIR_UP) begin
                        count_d = (mode == MODE_SAT) ? i_max : '0;
                    end else begin
                        count_d = (mode == MODE_SAT) ? '0 : i_max;
                    end
                end else begin
                    count_d = (dir == DIR_UP) ? count_q + WIDTH'(1)
                                              : count_q - WIDTH'(1);
                end
            end
            default: begin
                count_d = count_q;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_q <= WIDTH'(RST_COUNT);
            tc_q    <= RST_TC;
            ovf_q   <= RST_OVF;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign o_count = count_q;
    assign o_tc    = tc_q;
    assign o_ovf   = ovf_q;

endmodule

// File: doc/counter_ext.md
# counter_ext

Parametrised successor to the basic enable/clear counter: a single-clock up/down counter with synchronous load, programmable terminal value, wrap or saturate mode, terminal-count pulse and sticky overflow flag. It drops in wherever the basic counter is used, including synthesis-inspection wrappers. An optional prescaler is compiled in by macro.

## Interface
- WIDTH, 12, counter width in bits (≥2)
- PRESCALE_W, 8, prescaler compare width; only functional with the prescaler compiled in
- i_clk  in  1  clock; all state on rising edge
- i_rst_n  in  1  asynchronous, active-low reset; asserted any time, deasserted synchronously to i_clk by the parent
- i_en  in  1  count enable
- i_clear  in  1  synchronous clear
- i_load  in  1  synchronous load strobe
- i_load_val  in  WIDTH  value for load
- i_dir  in  1  1 = up, 0 = down
- i_mode  in  1  0 = wrap, 1 = saturate
- i_max  in  WIDTH  terminal value (quasi-static; change only while i_en=0)
- i_prescale  in  PRESCALE_W  step every i_prescale+1 enabled cycles; ignored without macro
- o_count  out  WIDTH  current count
- o_tc  out  1  one-cycle terminal-count pulse
- o_ovf  out  1  sticky boundary-hit flag

## Operation
- Priority per cycle: i_clear > i_load > step. Lower-priority actions are discarded.
- Clear: o_count←0, o_ovf←0, o_tc←0, prescaler←0.
- Load: o_count←i_load_val, written verbatim even if >i_max; prescaler←0; o_tc←0; o_ovf unchanged.
- Step condition: i_en & tick. tick=1 without macro.
- Boundary: up with o_count≥i_max; down with o_count==0.
- Non-boundary step: up +1, down −1.
- Boundary step, wrap mode: up→0, down→i_max.
- Boundary step, saturate mode: up→i_max (clamps a loaded value >i_max), down→0 (hold).
- Every boundary step: o_tc=1 for the following cycle; o_ovf←1.
- No step: o_count holds, o_tc=0.
- i_max=0: up wrap stays 0, o_tc pulses on each step; down behaves identically.
- Arithmetic is modulo 2^WIDTH internally but never reaches the natural wrap, because the boundary compare intercepts first.
- i_dir and i_mode are sampled per step; changing them between steps is legal.

## Timing
- Reset values: o_count=0, o_tc=0, o_ovf=0, prescaler=0. Reset is immediate and asynchronous.
- All outputs are registered. Latency from a sampled input to the output change is 1 cycle.
- o_tc and the boundary value of o_count appear on the same edge.
- o_tc is never asserted on two consecutive cycles unless boundary steps occur on consecutive cycles, as in saturate hold with tick every cycle.
- Reset mid-count abandons state. The first step after deassertion counts from 0.

## Configuration
- Macro COUNTER_EXT_PRESCALE_EN.
- Defined:
  - A PRESCALE_W-bit prescaler advances on each i_en cycle.
  - tick=1 when prescaler==i_prescale, and the prescaler then returns to 0.
  - i_en=0 freezes the prescaler.
  - i_prescale=0 gives a step every enabled cycle.
- Undefined:
  - tick is tied to 1 and no prescaler flops are built.
  - i_prescale is unused.
  - Behaviour equals the defined case with i_prescale=0.

## Structure
- Package counter_pkg:
  - enum counter_dir_e (DIR_DOWN=0, DIR_UP=1)
  - enum counter_mode_e (MODE_WRAP=0, MODE_SAT=1)
  - reset constants
- Sub-module counter_prescaler, instantiated only under the macro:
  - inputs: i_clk, i_rst_n, i_en, i_restart, i_prescale
  - output: o_tick

## Test plan
- Reset: assert i_rst_n=0 mid-count at o_count=0x123 → all outputs 0 immediately; after release, i_en=1 up → 1,2,3.
- Wrap up: i_max=5, up, wrap, i_en=1 from 0 → 1,2,3,4,5,0; o_tc=1 only with the 0; o_ovf=1 thereafter.
- Saturate down + load: load 2, down, sat → 1,0,0,0; o_tc pulses on each cycle at 0 after the first hold step; o_ovf=1.
- Priority: i_clear=i_load=i_en=1 with i_load_val=0x7 → o_count=0, o_ovf=0. Then i_load=i_en=1 → 0x7, no step.
- Over-max load: i_max=10, load 0xFFF, up, sat → next step gives 10 with o_tc=1. Repeat in wrap mode → 0 with o_tc=1.
- Prescaler (macro on): i_prescale=3, i_en=1 → o_count increments every 4th cycle. Dropping i_en for 2 cycles delays the next step by exactly 2 cycles.
